// File: rtl/mpu_fetch.sv
// Instruction sequencer: fetches bytes into the 48-bit decode window, hands complete
// instructions to the execution stage and advances or redirects the program counter.
module mpu_fetch #(
  parameter int unsigned MAX_ISIZE = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic        stop,
  output logic        mem_re,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [47:0] i,
  input  logic [15:0] dec_isize,
  input  logic        dec_error,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        exec_jump,
  input  logic [15:0] exec_jaddr,
  output logic [15:0] pc,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StExec,
    StWait,
    StHalt
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [47:0] r_i, w_i_nxt, w_window;
  logic [2:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [15:0] r_isize, w_isize_nxt, w_isize_cur;
  logic        r_stop_pend, w_stop_pend_nxt;
  logic        r_error, w_error_nxt;
  logic        w_dec_bad;
  logic        w_busy;

  assign w_busy    = (r_state != StIdle) && (r_state != StHalt);
  assign w_cnt_inc = r_cnt + 3'd1;
  // While byte 0 is being captured the decoder output is live; later bytes use the latched size.
  assign w_isize_cur = (r_cnt == 3'd0) ? dec_isize : r_isize;
  assign w_dec_bad   = dec_error || (dec_isize == 16'd0) || (dec_isize > 16'(MAX_ISIZE));

  // The incoming byte is merged into the window during CAPTURE so the decoder sees byte 0 in time.
  always_comb begin
    w_window = r_i;
    if (r_state == StCapture) begin
      for (int b = 0; b < 6; b++) begin
        if (r_cnt == 3'(b)) w_window[8*b +: 8] = mem_data;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_i_nxt         = r_i;
    w_cnt_nxt       = r_cnt;
    w_isize_nxt     = r_isize;
    w_stop_pend_nxt = r_stop_pend;
    w_error_nxt     = r_error;
    mem_re          = 1'b0;
    mem_addr        = 16'd0;
    exec_start      = 1'b0;

    if (w_busy && stop) w_stop_pend_nxt = 1'b1;

    case (r_state)
      StIdle, StHalt: begin
        if (start) begin
          w_pc_nxt        = start_addr;
          w_i_nxt         = 48'd0;
          w_cnt_nxt       = 3'd0;
          w_error_nxt     = 1'b0;
          w_stop_pend_nxt = 1'b0;
          w_state_nxt     = StFetch;
        end
      end
      StFetch: begin
        mem_re      = 1'b1;
        mem_addr    = r_pc + {13'd0, r_cnt};
        w_state_nxt = StCapture;
      end
      StCapture: begin
        w_i_nxt   = w_window;
        w_cnt_nxt = w_cnt_inc;
        if ((w_cnt_inc == 3'd1) && w_dec_bad) begin
          w_error_nxt = 1'b1;
          w_state_nxt = StHalt;
        end else begin
          if (w_cnt_inc == 3'd1) w_isize_nxt = dec_isize;
          if ({13'd0, w_cnt_inc} == w_isize_cur) w_state_nxt = StExec;
          else                                   w_state_nxt = StFetch;
        end
      end
      StExec: begin
        exec_start  = 1'b1;
        w_state_nxt = StWait;
      end
      StWait: begin
        if (exec_done) begin
          w_pc_nxt  = exec_jump ? exec_jaddr : r_pc + r_isize;
          w_i_nxt   = 48'd0;
          w_cnt_nxt = 3'd0;
          // A stop arriving together with exec_done still takes effect at this boundary.
          if (r_stop_pend || stop) begin
            w_stop_pend_nxt = 1'b0;
            w_state_nxt     = StIdle;
          end else begin
            w_state_nxt = StFetch;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= StIdle;
      r_pc        <= 16'd0;
      r_i         <= 48'd0;
      r_cnt       <= 3'd0;
      r_isize     <= 16'd0;
      r_stop_pend <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_i         <= w_i_nxt;
      r_cnt       <= w_cnt_nxt;
      r_isize     <= w_isize_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign i     = w_window;
  assign pc    = r_pc;
  assign busy  = w_busy;
  assign error = r_error;

endmodule

// File: tb/tb_mpu_fetch.sv
// Bench for mpu_fetch: byte memory and decoder stubs plus an instruction-level reference model.
module tb_mpu_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [15:0] start_addr;
  logic        stop;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [47:0] i;
  logic [15:0] dec_isize;
  logic        dec_error;
  logic        exec_start;
  logic        exec_done;
  logic        exec_jump;
  logic [15:0] exec_jaddr;
  logic [15:0] pc;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] m_pc;
  bit          m_stop_pend;
  bit          m_running;

  mpu_fetch #(.MAX_ISIZE(6)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .start_addr(start_addr),
    .stop(stop), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data), .i(i),
    .dec_isize(dec_isize), .dec_error(dec_error), .exec_start(exec_start),
    .exec_done(exec_done), .exec_jump(exec_jump), .exec_jaddr(exec_jaddr), .pc(pc),
    .busy(busy), .error(error)
  );

  always #5 sys_clk = ~sys_clk;

  // Read data is valid only in the cycle after mem_re; otherwise junk.
  always @(posedge sys_clk) mem_data <= mem_re ? mem[mem_addr] : 8'($urandom);

  // Decoder stub: size depends only on the opcode byte.
  function automatic logic [15:0] dec_sz(input logic [7:0] op);
    case (op)
      8'hE0:   return 16'd3;
      8'hF0:   return 16'd2;
      8'h10:   return 16'd5;
      8'h30:   return 16'd4;
      8'hFF:   return 16'h0103;
      8'h00:   return 16'd0;
      default: return {13'd0, op[2:0]};
    endcase
  endfunction

  function automatic logic dec_er(input logic [7:0] op);
    return op == 8'h00;
  endfunction

  assign dec_isize = dec_sz(i[7:0]);
  assign dec_error = dec_er(i[7:0]);

  function automatic void ref_dec(input logic [7:0] op, output int n, output bit bad);
    logic [15:0] sz;
    sz  = dec_sz(op);
    bad = dec_er(op) || (sz == 16'd0) || (sz > 16'd6);
    n   = int'(sz);
  endfunction

  task automatic rst_dut();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst     = 1'b0;
    m_pc        = 16'd0;
    m_stop_pend = 1'b0;
    m_running   = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first FETCH cycle.
  task automatic do_start(input logic [15:0] addr);
    @(negedge sys_clk);
    start      = 1'b1;
    start_addr = addr;
    @(negedge sys_clk);
    start       = 1'b0;
    start_addr  = 16'($urandom);
    m_pc        = addr;
    m_stop_pend = 1'b0;
    m_running   = 1'b1;
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== addr || busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL start_fetch: re=%b addr=%h busy=%b err=%b want re=1 addr=%h busy=1 err=0",
               mem_re, mem_addr, busy, error, addr);
    end
  endtask

  // Runs one instruction at m_pc; entered at the negedge of its first FETCH cycle.
  task automatic exec_one(input bit jump, input logic [15:0] jaddr, input int stop_at,
                          input bit stop_with_done);
    int          n, start_cyc, nstart, d;
    bit          bad, ok, stop_now;
    logic [47:0] exp_win;
    logic [15:0] a;
    logic [15:0] addrs[$];
    ref_dec(mem[m_pc], n, bad);
    addrs     = {};
    start_cyc = -1;
    nstart    = 0;
    if (bad) begin
      for (int c = 0; c <= 2; c++) begin
        if (mem_re) addrs.push_back(mem_addr);
        if (exec_start) nstart++;
        if (c < 2) @(negedge sys_clk);
      end
      ok = (addrs.size() == 1) && (nstart == 0);
      if (ok) ok = (addrs[0] === m_pc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL halt_reads: reads=%0d starts=%0d want one read at %h, no start",
                 addrs.size(), nstart, m_pc);
      end
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || pc !== m_pc || mem_re !== 1'b0) begin
        errors++;
        $display("FAIL halt_state: err=%b busy=%b pc=%h re=%b want err=1 busy=0 pc=%h re=0",
                 error, busy, pc, mem_re, m_pc);
      end
      m_running = 1'b0;
      return;
    end
    exp_win = 48'd0;
    for (int k = 0; k < n; k++) begin
      a = m_pc + 16'(k);
      exp_win[8*k +: 8] = mem[a];
    end
    for (int c = 0; c <= 2 * n; c++) begin
      if (mem_re) addrs.push_back(mem_addr);
      if (exec_start) begin
        nstart++;
        start_cyc = c;
      end
      stop = (c == stop_at);
      if (c == stop_at) m_stop_pend = 1'b1;
      if (c < 2 * n) @(negedge sys_clk);
    end
    ok = (addrs.size() == n);
    for (int k = 0; k < n; k++) begin
      a = m_pc + 16'(k);
      if (ok && addrs[k] !== a) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fetch_addrs: got %0d reads want %0d sequential from %h", addrs.size(), n,
               m_pc);
    end
    checks++;
    if (nstart != 1 || start_cyc != 2 * n) begin
      errors++;
      $display("FAIL exec_timing: starts=%0d at cycle %0d want 1 at cycle %0d", nstart,
               start_cyc, 2 * n);
    end
    checks++;
    if (i !== exp_win) begin
      errors++;
      $display("FAIL window: got %h want %h", i, exp_win);
    end
    @(negedge sys_clk);
    stop       = 1'b0;
    start      = ($urandom_range(0, 2) == 0);
    start_addr = 16'($urandom);
    d = $urandom_range(0, 3);
    for (int c = 0; c < d; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
      checks++;
      if (exec_start !== 1'b0 || mem_re !== 1'b0 || i !== exp_win || busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_hold: start=%b re=%b busy=%b i=%h want 0 0 1 %h", exec_start,
                 mem_re, busy, i, exp_win);
      end
    end
    exec_done  = 1'b1;
    exec_jump  = jump;
    exec_jaddr = jaddr;
    stop       = stop_with_done;
    @(negedge sys_clk);
    exec_done  = 1'b0;
    stop       = 1'b0;
    start      = 1'b0;
    exec_jump  = 1'($urandom);
    exec_jaddr = 16'($urandom);
    m_pc        = jump ? jaddr : m_pc + 16'(n);
    stop_now    = m_stop_pend || stop_with_done;
    m_stop_pend = 1'b0;
    m_running   = !stop_now;
    checks++;
    if (pc !== m_pc || busy !== !stop_now || mem_re !== !stop_now ||
        (!stop_now && mem_addr !== m_pc)) begin
      errors++;
      $display("FAIL after_done: pc=%h busy=%b re=%b addr=%h want pc=%h busy=%b re=%b", pc,
               busy, mem_re, mem_addr, m_pc, !stop_now, !stop_now);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    checks++;
    if (mem_re !== 1'b0 || mem_addr !== 16'd0 || exec_start !== 1'b0 || busy !== 1'b0 ||
        error !== 1'b0 || pc !== 16'd0 || i !== 48'd0) begin
      errors++;
      $display("FAIL reset_vals: re=%b addr=%h xs=%b busy=%b err=%b pc=%h i=%h want all 0",
               mem_re, mem_addr, exec_start, busy, error, pc, i);
    end
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%b re=%b want 0 0", busy, mem_re);
    end
  endtask

  task automatic test_basic();
    rst_dut();
    mem[16'h0010] = 8'hE0;
    mem[16'h0011] = 8'h05;
    mem[16'h0012] = 8'hAA;
    do_start(16'h0010);
    exec_one(1'b0, 16'h0000, -1, 1'b0);
    checks++;
    if (pc !== 16'h0013 || mem_addr !== 16'h0013) begin
      errors++;
      $display("FAIL basic_next: pc=%h addr=%h want 0013 0013", pc, mem_addr);
    end
  endtask

  task automatic test_jump();
    rst_dut();
    mem[16'h0020] = 8'hF0;
    mem[16'h0021] = 8'h08;
    do_start(16'h0020);
    exec_one(1'b1, 16'h0100, -1, 1'b0);
    checks++;
    if (pc !== 16'h0100 || mem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL jump_next: pc=%h addr=%h want 0100 0100", pc, mem_addr);
    end
  endtask

  task automatic test_error();
    rst_dut();
    mem[16'h0030] = 8'h00;
    do_start(16'h0030);
    exec_one(1'b0, 16'h0000, -1, 1'b0);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (pc !== 16'h0030 || error !== 1'b1 || busy !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen: pc=%h err=%b busy=%b re=%b want 0030 1 0 0", pc, error,
               busy, mem_re);
    end
    do_start(16'h0010);
    exec_one(1'b0, 16'h0000, -1, 1'b1);
  endtask

  task automatic test_stop();
    rst_dut();
    mem[16'h0040] = 8'h10;
    do_start(16'h0040);
    exec_one(1'b0, 16'h0000, 2, 1'b0);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (pc !== 16'h0045 || busy !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: pc=%h busy=%b re=%b want 0045 0 0", pc, busy, mem_re);
    end
  endtask

  task automatic test_wrap();
    rst_dut();
    mem[16'hFFFE] = 8'h30;
    do_start(16'hFFFE);
    exec_one(1'b0, 16'h0000, -1, 1'b1);
    checks++;
    if (pc !== 16'h0002) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h want 0002", pc);
    end
  endtask

  task automatic test_reset_in_wait();
    rst_dut();
    mem[16'h0010] = 8'hE0;
    do_start(16'h0010);
    repeat (7) @(negedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || exec_start !== 1'b0 || pc !== 16'd0 || i !== 48'd0 ||
        mem_re !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: busy=%b xs=%b pc=%h i=%h re=%b want all 0", busy,
               exec_start, pc, i, mem_re);
    end
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    exec_done = 1'b1;
    exec_jump = 1'b0;
    @(negedge sys_clk);
    exec_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0 || pc !== 16'd0) begin
      errors++;
      $display("FAIL late_done: busy=%b re=%b pc=%h want 0 0 0000", busy, mem_re, pc);
    end
  endtask

  task automatic test_random();
    rst_dut();
    for (int it = 0; it < 40; it++) begin
      if (!m_running) begin
        if ($urandom_range(0, 1) == 1) begin
          @(negedge sys_clk);
          stop = 1'b1;
          @(negedge sys_clk);
          stop = 1'b0;
        end
        do_start(16'($urandom));
      end
      exec_one($urandom_range(0, 3) == 0, 16'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
               $urandom_range(0, 5) == 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst    = 1'b1;
    start      = 1'b0;
    start_addr = 16'd0;
    stop       = 1'b0;
    exec_done  = 1'b0;
    exec_jump  = 1'b0;
    exec_jaddr = 16'd0;
    for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
    test_reset();
    test_basic();
    test_jump();
    test_error();
    test_stop();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpu_fetch.md
Name: mpu_fetch

Overview:
- Instruction sequencer for the MPU.
- Fetches instruction bytes from a byte-wide instruction memory and assembles the 48-bit decode window for mpu_decoder.
- Uses the decoder's size and error outputs to decide how many bytes to fetch.
- Hands each complete instruction to the execution stage, then advances or redirects the program counter.

Parameters:
MAX_ISIZE, 6, largest legal instruction size in bytes; a decoded isize above this, or equal to 0, is a decode error.

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; starts execution at start_addr (honoured in IDLE and HALT only)
start_addr  input  16  first instruction address
stop  input  1  one-cycle pulse; request stop at the next instruction boundary
mem_re  output  1  instruction memory read strobe
mem_addr  output  16  instruction memory byte address
mem_data  input  8  read data, valid exactly 1 cycle after mem_re
i  output  48  decode window to mpu_decoder; byte n at i[8n+7:8n]
dec_isize  input  16  decoder instruction size
dec_error  input  1  decoder error
exec_start  output  1  one-cycle pulse; i is stable and valid
exec_done  input  1  execution finished
exec_jump  input  1  sampled with exec_done; branch taken
exec_jaddr  input  16  sampled with exec_done; branch target
pc  output  16  address of current instruction
busy  output  1  high in every state except IDLE and HALT
error  output  1  sticky decode error flag

Behaviour:
- Reset values (asynchronous):
  - State IDLE; pc=0, i=0, cnt=0, stop_pend=0.
  - mem_re=0, mem_addr=0, exec_start=0, busy=0, error=0.
- States: IDLE, FETCH, CAPTURE, EXEC, WAIT, HALT.
- IDLE: on start, pc<=start_addr, i<=0, cnt<=0, error<=0 -> FETCH.
- FETCH: mem_re=1, mem_addr=pc+cnt (16-bit wrap) -> CAPTURE. mem_re is 0 in all other states.
- CAPTURE: i[8*cnt+:8]<=mem_data, cnt<=cnt+1. The next state is decided using the post-increment cnt (with byte 0 already in the window, since the decoder's isize and error depend only on i[7:0]):
  - If cnt_new==1 and (dec_error, or dec_isize==0, or dec_isize>MAX_ISIZE): error<=1 -> HALT.
  - Else if cnt_new==dec_isize: -> EXEC.
  - Else: -> FETCH.
- Bytes beyond isize stay 0 in i.
- EXEC: exec_start=1 for exactly this cycle -> WAIT.
- WAIT: i held stable. exec_done is sampled from the cycle after exec_start onward. On exec_done:
  - pc<=exec_jump ? exec_jaddr : pc+isize (16-bit wrap, isize latched at CAPTURE).
  - i<=0, cnt<=0.
  - If stop_pend or stop is asserted in this cycle: stop_pend<=0 -> IDLE. Otherwise -> FETCH.
- stop: a pulse in FETCH/CAPTURE/EXEC/WAIT sets stop_pend. The current instruction always completes. stop in IDLE/HALT is ignored.
- start while busy is ignored.
- HALT: error=1, pc frozen at the faulting instruction, busy=0. start clears error and restarts as from IDLE.
- Timing: 2 cycles per byte. An N-byte instruction asserts exec_start 2N cycles after FETCH entry. Next fetch mem_re is 1 cycle after exec_done.
- Simultaneous stop and exec_done: stop wins; go to IDLE with pc updated.
- Reset mid-operation: immediate return to reset values. No pending memory read is retained.

Test Plan:
1. Memory[0x10..0x12]=E0 05 AA; start, start_addr=0x0010 -> mem_addr 0x10, 0x11, 0x12 on alternate cycles; i=0x0000_00AA_05E0; exec_start 6 cycles after FETCH entry; exec_done with exec_jump=0 -> pc=0x0013, next mem_addr=0x0013.
2. Memory[0x20]=F0, [0x21]=08; exec_done with exec_jump=1, exec_jaddr=0x0100 -> pc=0x0100; next read at 0x0100.
3. Memory[0x30]=00, decoder reports error -> single read at 0x30; error=1, busy=0, exec_start never pulses, pc=0x0030. A start pulse clears error and refetches from start_addr.
4. stop pulsed during the second byte of a 5-byte 0x10 instruction at 0x40 -> all 5 bytes fetched, exec_start pulses; after exec_done: IDLE, busy=0, pc=0x0045, no further mem_re.
5. pc=0xFFFE, 4-byte 0x30 instruction -> reads at FFFE, FFFF, 0000, 0001; pc after exec_done=0x0002.
6. sys_rst asserted in WAIT -> same-cycle asynchronous clear: busy=0, exec_start=0, pc=0, i=0. A late exec_done is ignored in IDLE.
